inst_fetcher: RTL and testbench

// - Per-core instruction fetch stage. It sits directly downstream of the PC unit and consumes current_pc.
// - Returns the 16-bit instruction at current_pc to the decoder.
// - Fronts the program-memory controller with a small direct-mapped instruction cache. Loop bodies and
//   SSY/SYNC reconvergence paths re-fetch without a memory round-trip.
// - The core scheduler advances FETCH->DECODE when fetcher_state==FETCHED.

---
 rtl/gpu_pkg.sv | 27 ++
 rtl/icache_array.sv | 48 ++++
 rtl/inst_fetcher.sv | 128 ++++++++++++
 tb/tb_inst_fetcher.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared encodings for the core scheduler and fetch stage, plus a saturating counter helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gpu_pkg;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_t;

    typedef enum logic [2:0] {
        FS_IDLE     = 3'b000,
        FS_FETCHING = 3'b001,
        FS_FETCHED  = 3'b010
    } fetch_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped instruction store: valid/tag/data per line, combinational lookup, synchronous fill.
// Latency: read 0 cycles, write and flush take effect at the next edge.
// Backpressure: none; a flush in the same cycle as a fill leaves the line invalid.
module icache_array #(
    parameter int LINES     = 16,
    parameter int IDX_BITS  = 4,
    parameter int TAG_BITS  = 5,
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IDX_BITS-1:0]  rd_idx,
    input  logic [TAG_BITS-1:0]  rd_tag,
    output logic                 rd_hit,
    output logic [DATA_BITS-1:0] rd_data,
    input  logic                 wr_en,
    input  logic [IDX_BITS-1:0]  wr_idx,
    input  logic [TAG_BITS-1:0]  wr_tag,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 flush
);

    logic [LINES-1:0]     valid_q;
    logic [TAG_BITS-1:0]  tag_q  [LINES];
    logic [DATA_BITS-1:0] data_q [LINES];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Payload is unreset; valid_q alone decides whether a line can hit.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_hit  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_data = data_q[rd_idx];

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetch stage: returns the instruction at current_pc, via a direct-mapped cache or program memory.
// Latency: hit 1 cycle, miss 1 + memory latency.
// Backpressure: request held until mem_read_ready; result held in FETCHED until core_state==DECODE.
module inst_fetcher
    import gpu_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int CACHE_LINES           = 16,
    parameter int CACHE_ENABLE          = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             icache_flush,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic [15:0]                      hit_count,
    output logic [15:0]                      miss_count
);

    localparam int AB       = PROGRAM_MEM_ADDR_BITS;
    localparam int DB       = PROGRAM_MEM_DATA_BITS;
    localparam int IDX_BITS = $clog2(CACHE_LINES);
    // One spare tag bit keeps the width legal when the cache covers the whole address space.
    localparam int TAG_BITS = AB - IDX_BITS + 1;

    fetch_state_t state_q, state_d;

    logic [IDX_BITS-1:0] lookup_idx, fill_idx;
    logic [TAG_BITS-1:0] lookup_tag, fill_tag;
    logic                array_hit, hit;
    logic [DB-1:0]       array_data;
    logic                lookup_go, fill_go, fill_wr;

    assign lookup_idx = current_pc[IDX_BITS-1:0];
    assign lookup_tag = TAG_BITS'({1'b0, current_pc} >> IDX_BITS);
    // Fill uses the latched request address so a drifting PC cannot corrupt the line.
    assign fill_idx   = mem_read_address[IDX_BITS-1:0];
    assign fill_tag   = TAG_BITS'({1'b0, mem_read_address} >> IDX_BITS);

    assign hit     = array_hit && (CACHE_ENABLE != 0);
    assign fill_wr = fill_go && (CACHE_ENABLE != 0);

    icache_array #(
        .LINES     (CACHE_LINES),
        .IDX_BITS  (IDX_BITS),
        .TAG_BITS  (TAG_BITS),
        .DATA_BITS (DB)
    ) u_icache_array (
        .clk     (clk),
        .reset   (reset),
        .rd_idx  (lookup_idx),
        .rd_tag  (lookup_tag),
        .rd_hit  (array_hit),
        .rd_data (array_data),
        .wr_en   (fill_wr),
        .wr_idx  (fill_idx),
        .wr_tag  (fill_tag),
        .wr_data (mem_read_data),
        .flush   (icache_flush)
    );

    always_comb begin
        state_d   = state_q;
        lookup_go = 1'b0;
        fill_go   = 1'b0;
        case (state_q)
            FS_IDLE: begin
                if (core_state == CORE_FETCH) begin
                    lookup_go = 1'b1;
                    state_d   = hit ? FS_FETCHED : FS_FETCHING;
                end
            end
            FS_FETCHING: begin
                if (mem_read_ready && mem_read_valid) begin
                    fill_go = 1'b1;
                    state_d = FS_FETCHED;
                end
            end
            FS_FETCHED: begin
                if (core_state == CORE_DECODE) begin
                    state_d = FS_IDLE;
                end
            end
            default: state_d = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_read_valid   <= 1'b0;
            mem_read_address <= '0;
            instruction      <= '0;
            hit_count        <= '0;
            miss_count       <= '0;
        end else begin
            if (lookup_go && hit) begin
                instruction <= array_data;
                hit_count   <= sat_inc16(hit_count);
            end else if (lookup_go) begin
                mem_read_valid   <= 1'b1;
                mem_read_address <= current_pc;
                miss_count       <= sat_inc16(miss_count);
            end
            if (fill_go) begin
                instruction    <= mem_read_data;
                mem_read_valid <= 1'b0;
            end
        end
    end

    assign fetcher_state = state_q;

endmodule

// File: tb/tb_inst_fetcher.sv
module tb_inst_fetcher;

    localparam logic [2:0] C_IDLE   = 3'b000;
    localparam logic [2:0] C_FETCH  = 3'b001;
    localparam logic [2:0] C_DECODE = 3'b010;
    localparam logic [2:0] S_IDLE     = 3'b000;
    localparam logic [2:0] S_FETCHING = 3'b001;
    localparam logic [2:0] S_FETCHED  = 3'b010;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic        icache_flush;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;
    logic [2:0]  fetcher_state;
    logic [15:0] instruction;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int checks = 0;
    int errors = 0;

    // Reference cache model and scoreboard
    logic        m_valid [16];
    logic [3:0]  m_tag   [16];
    logic [15:0] m_data  [16];
    logic [15:0] exp_q [$];
    logic [15:0] last_instr;
    int          exp_hits;
    int          exp_misses;

    always #5 clk = ~clk;

    inst_fetcher dut (
        .clk              (clk),
        .reset            (reset),
        .core_state       (core_state),
        .current_pc       (current_pc),
        .icache_flush     (icache_flush),
        .mem_read_valid   (mem_read_valid),
        .mem_read_address (mem_read_address),
        .mem_read_ready   (mem_read_ready),
        .mem_read_data    (mem_read_data),
        .fetcher_state    (fetcher_state),
        .instruction      (instruction),
        .hit_count        (hit_count),
        .miss_count       (miss_count)
    );

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
        last_instr = 16'h0000;
    endtask

    task automatic model_flush();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    // fmode: 0 none, 1 flush coincident with lookup, 2 flush coincident with fill
    task automatic fetch(input logic [7:0] pc, input logic [15:0] mdata, input int lat, input int fmode);
        int         idx;
        logic       exp_hit;
        logic [15:0] exp_instr;
        idx     = int'(pc[3:0]);
        exp_hit = m_valid[idx] && (m_tag[idx] == pc[7:4]);
        exp_q.push_back(exp_hit ? m_data[idx] : mdata);
        current_pc   = pc;
        core_state   = C_FETCH;
        icache_flush = (fmode == 1);
        @(negedge clk);
        icache_flush = 1'b0;
        if (fmode == 1) model_flush();
        if (exp_hit) begin
            exp_hits++;
            checks++;
            if (fetcher_state !== S_FETCHED || mem_read_valid !== 1'b0) begin
                errors++;
                $display("FAIL hit_lookup pc=%h state=%b valid=%b expected state=%b valid=0",
                         pc, fetcher_state, mem_read_valid, S_FETCHED);
            end
        end else begin
            exp_misses++;
            checks++;
            if (fetcher_state !== S_FETCHING || mem_read_valid !== 1'b1 || mem_read_address !== pc) begin
                errors++;
                $display("FAIL miss_request pc=%h state=%b valid=%b addr=%h expected state=%b valid=1 addr=%h",
                         pc, fetcher_state, mem_read_valid, mem_read_address, S_FETCHING, pc);
            end
            for (int i = 1; i < lat; i++) begin
                @(negedge clk);
                checks++;
                if (fetcher_state !== S_FETCHING || mem_read_valid !== 1'b1 || mem_read_address !== pc) begin
                    errors++;
                    $display("FAIL request_hold pc=%h cycle=%0d state=%b valid=%b addr=%h", pc, i,
                             fetcher_state, mem_read_valid, mem_read_address);
                end
            end
            mem_read_ready = 1'b1;
            mem_read_data  = mdata;
            icache_flush   = (fmode == 2);
            @(negedge clk);
            mem_read_ready = 1'b0;
            mem_read_data  = 16'h0000;
            icache_flush   = 1'b0;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = pc[7:4];
            m_data[idx]  = mdata;
            if (fmode == 2) model_flush();
        end
        exp_instr  = exp_q.pop_front();
        last_instr = exp_instr;
        checks++;
        if (fetcher_state !== S_FETCHED || instruction !== exp_instr || mem_read_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetched pc=%h state=%b instr=%h valid=%b expected state=%b instr=%h valid=0",
                     pc, fetcher_state, instruction, mem_read_valid, S_FETCHED, exp_instr);
        end
        // FETCH still asserted while FETCHED must not restart the fetch
        @(negedge clk);
        checks++;
        if (fetcher_state !== S_FETCHED || mem_read_valid !== 1'b0 || instruction !== exp_instr) begin
            errors++;
            $display("FAIL fetched_hold pc=%h state=%b valid=%b instr=%h expected instr=%h",
                     pc, fetcher_state, mem_read_valid, instruction, exp_instr);
        end
        core_state = C_DECODE;
        @(negedge clk);
        core_state = C_IDLE;
        checks++;
        if (fetcher_state !== S_IDLE || instruction !== exp_instr) begin
            errors++;
            $display("FAIL decode_return pc=%h state=%b instr=%h expected state=000 instr=%h",
                     pc, fetcher_state, instruction, exp_instr);
        end
        checks++;
        if (hit_count !== 16'(exp_hits) || miss_count !== 16'(exp_misses)) begin
            errors++;
            $display("FAIL counters pc=%h hits=%0d misses=%0d expected hits=%0d misses=%0d",
                     pc, hit_count, miss_count, exp_hits, exp_misses);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_clear();
        checks++;
        if (mem_read_valid !== 1'b0 || fetcher_state !== S_IDLE || instruction !== 16'h0000 ||
            hit_count !== 16'h0000 || miss_count !== 16'h0000 || mem_read_address !== 8'h00) begin
            errors++;
            $display("FAIL reset_state valid=%b state=%b instr=%h hits=%0d misses=%0d addr=%h expected all zero",
                     mem_read_valid, fetcher_state, instruction, hit_count, miss_count, mem_read_address);
        end
    endtask

    task automatic test_cold_miss();
        fetch(8'h05, 16'h1234, 3, 0);
        checks++;
        if (miss_count !== 16'd1) begin
            errors++;
            $display("FAIL cold_miss_count got %0d expected 1", miss_count);
        end
    endtask

    task automatic test_hit();
        fetch(8'h05, 16'hDEAD, 2, 0);
        checks++;
        if (hit_count !== 16'd1 || instruction !== 16'h1234) begin
            errors++;
            $display("FAIL hit_result hits=%0d instr=%h expected hits=1 instr=1234", hit_count, instruction);
        end
    endtask

    task automatic test_conflict();
        fetch(8'h15, 16'hABCD, 2, 0);
        fetch(8'h05, 16'h1234, 3, 0);
        checks++;
        if (miss_count !== 16'd3 || instruction !== 16'h1234) begin
            errors++;
            $display("FAIL conflict misses=%0d instr=%h expected misses=3 instr=1234", miss_count, instruction);
        end
    endtask

    task automatic test_flush_on_fill();
        int m0;
        fetch(8'h07, 16'hBEEF, 2, 2);
        m0 = int'(miss_count);
        fetch(8'h07, 16'hBEEF, 1, 0);
        checks++;
        if (int'(miss_count) != m0 + 1) begin
            errors++;
            $display("FAIL flush_fill_refetch misses=%0d expected %0d", miss_count, m0 + 1);
        end
    endtask

    task automatic test_flush_on_lookup();
        int h0;
        h0 = int'(hit_count);
        fetch(8'h07, 16'h0000, 1, 1);
        checks++;
        if (int'(hit_count) != h0 + 1) begin
            errors++;
            $display("FAIL flush_lookup_hit hits=%0d expected %0d", hit_count, h0 + 1);
        end
        fetch(8'h07, 16'h7777, 2, 0);
    endtask

    task automatic test_stray_ready();
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hF00D;
        current_pc     = 8'h33;
        @(negedge clk);
        mem_read_ready = 1'b0;
        mem_read_data  = 16'h0000;
        checks++;
        if (fetcher_state !== S_IDLE || instruction !== last_instr || mem_read_valid !== 1'b0) begin
            errors++;
            $display("FAIL stray_ready state=%b instr=%h valid=%b expected state=000 instr=%h valid=0",
                     fetcher_state, instruction, mem_read_valid, last_instr);
        end
        fetch(8'h33, 16'h3333, 2, 0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] pcs [10];
        pcs = '{8'h40, 8'h41, 8'h40, 8'h50, 8'h40, 8'h41, 8'hFF, 8'h0F, 8'hFF, 8'h0F};
        for (int i = 0; i < 10; i++) begin
            fetch(pcs[i], {pcs[i], ~pcs[i]}, 1 + (i % 3), 0);
        end
    endtask

    task automatic test_reset_mid_fetch();
        current_pc = 8'h05;
        core_state = C_FETCH;
        @(negedge clk);
        checks++;
        if (fetcher_state !== S_FETCHING || mem_read_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_fetch state=%b valid=%b expected 001 and 1", fetcher_state, mem_read_valid);
        end
        reset      = 1'b1;
        core_state = C_IDLE;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        checks++;
        if (mem_read_valid !== 1'b0 || fetcher_state !== S_IDLE || hit_count !== 16'h0 || miss_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid_fetch valid=%b state=%b hits=%0d misses=%0d expected all zero",
                     mem_read_valid, fetcher_state, hit_count, miss_count);
        end
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hBAD0;
        @(negedge clk);
        mem_read_ready = 1'b0;
        mem_read_data  = 16'h0000;
        checks++;
        if (fetcher_state !== S_IDLE || instruction !== 16'h0000) begin
            errors++;
            $display("FAIL stale_ready state=%b instr=%h expected state=000 instr=0000", fetcher_state, instruction);
        end
        fetch(8'h05, 16'h5555, 2, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        core_state     = C_IDLE;
        current_pc     = 8'h00;
        icache_flush   = 1'b0;
        mem_read_ready = 1'b0;
        mem_read_data  = 16'h0000;
        model_clear();
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush_on_fill();
        test_flush_on_lookup();
        test_stray_ready();
        test_back_to_back();
        test_reset_mid_fetch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
